// File: rtl/div_32_if.sv
// div_32_if: request/response bundle for the iterative divider.
// The master drives start/op/operands; the slave returns busy, a one-cycle valid and the result.
interface div_32_if #(
  parameter int WIDTH = 32
);
  logic             i_div_start;
  logic [1:0]       i_div_op;
  logic [WIDTH-1:0] i_div_a;
  logic [WIDTH-1:0] i_div_b;
  logic             o_div_busy;
  logic             o_div_valid;
  logic [WIDTH-1:0] o_div_result;

  modport master (
    output i_div_start, i_div_op, i_div_a, i_div_b,
    input  o_div_busy, o_div_valid, o_div_result
  );

  modport slave (
    input  i_div_start, i_div_op, i_div_a, i_div_b,
    output o_div_busy, o_div_valid, o_div_result
  );
endinterface

// File: rtl/div_32.sv
// div_32: restoring divider (DIV/DIVU/REM/REMU), result valid WIDTH+1 cycles after an accepted start.
// Start is ignored while busy; DIV_EARLY_OUT_EN sends divide-by-zero and signed overflow straight to DONE.
module div_32 #(
  parameter int WIDTH = 32
) (
  input  logic     i_clk,
  input  logic     i_reset,
  div_32_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  function automatic logic [WIDTH-1:0] special_result(input logic [1:0] op,
                                                      input logic [WIDTH-1:0] a,
                                                      input logic dz);
    if (dz) return op[1] ? a : ALL_ONES;
    return op[1] ? '0 : MIN_NEG;
  endfunction

  logic             in_signed, in_dz, in_ovf, accept;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] step_rem, step_quo, fin_rem, fin_quo, fin_res;

  always_comb begin
    in_signed = ~bus.i_div_op[0];
    in_dz     = (bus.i_div_b == '0);
    in_ovf    = in_signed && (bus.i_div_a == MIN_NEG) && (bus.i_div_b == ALL_ONES);
    a_abs     = (in_signed && bus.i_div_a[WIDTH-1]) ? -bus.i_div_a : bus.i_div_a;
    b_abs     = (in_signed && bus.i_div_b[WIDTH-1]) ? -bus.i_div_b : bus.i_div_b;
    accept    = bus.i_div_start && (state_q != CALC);

    // The shifted partial remainder needs one extra bit before the compare.
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    ge       = (rem_sh >= {1'b0, dvs_q});
    step_rem = ge ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], ge};
    fin_quo  = neg_quo_q ? -step_quo : step_quo;
    fin_rem  = neg_rem_q ? -step_rem : step_rem;
    fin_res  = (dz_q || ovf_q) ? special_result(op_q, a_q, dz_q)
                               : (op_q[1] ? fin_rem : fin_quo);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    a_d       = a_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;

    if (accept) begin
      op_d      = bus.i_div_op;
      a_d       = bus.i_div_a;
      rem_d     = '0;
      quo_d     = a_abs;
      dvs_d     = b_abs;
      cnt_d     = '0;
      neg_quo_d = in_signed && (bus.i_div_a[WIDTH-1] ^ bus.i_div_b[WIDTH-1]);
      neg_rem_d = in_signed && bus.i_div_a[WIDTH-1];
      dz_d      = in_dz;
      ovf_d     = in_ovf;
      state_d   = CALC;
`ifdef DIV_EARLY_OUT_EN
      if (in_dz || in_ovf) begin
        state_d = DONE;
        res_d   = special_result(bus.i_div_op, bus.i_div_a, in_dz);
      end
`endif
    end else begin
      case (state_q)
        CALC: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d = DONE;
            res_d   = fin_res;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      a_q       <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      a_q       <= a_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.o_div_busy   = (state_q == CALC);
  assign bus.o_div_valid  = (state_q == DONE);
  assign bus.o_div_result = res_q;
endmodule

// File: tb/tb_div_32.sv
// tb_div_32: random and directed divider traffic, checked by a scoreboard against plain SV arithmetic.
module tb_div_32;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_32_if #(.WIDTH(32)) bus ();
  div_32 #(.WIDTH(32)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  typedef struct {
    logic [31:0] res;
    longint      at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  longint      cyc      = 0;
  logic [31:0] last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`else
    if (op == 2'b00 && a == 32'd0 && b == 32'd0) return 33;
`endif
    return 33;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.o_div_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result", bus.o_div_result, mon_e.res);
        check("latency_cycle", 32'(cyc), 32'(mon_e.at));
      end
    end
  end

  // Called just after a negedge; returns one negedge later with start dropped.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    bus.i_div_start = 1'b1;
    bus.i_div_op    = op;
    bus.i_div_a     = a;
    bus.i_div_b     = b;
    if (push) begin
      e.res    = ref_div(op, a, b);
      e.at     = cyc + longint'(ref_lat(op, a, b));
      last_exp = e.res;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.i_div_start = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (bus.o_div_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout actual=0 expected=1 (cycle %0d)", cyc);
    end
  endtask

  logic [1:0]  d_op[10] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
  logic [31:0] d_a[10]  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000,
                            32'h8000_0000, 32'd5, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
  logic [31:0] d_b[10]  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};

  initial begin
    #5_000_000;
    $display("FAIL watchdog_expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          gap;

    // Reset with a coincident start: reset must win.
    rst = 1'b1;
    bus.i_div_start = 1'b1;
    bus.i_div_op    = 2'b01;
    bus.i_div_a     = 32'd100;
    bus.i_div_b     = 32'd7;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.o_div_busy), 32'd0);
    check("reset_valid", 32'(bus.o_div_valid), 32'd0);
    check("reset_result", bus.o_div_result, 32'd0);
    rst = 1'b0;
    bus.i_div_start = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(bus.o_div_busy), 32'd0);

    for (int i = 0; i < 10; i++) begin
      issue(d_op[i], d_a[i], d_b[i], 1'b1);
      check("calc_busy", 32'(bus.o_div_busy), (ref_lat(d_op[i], d_a[i], d_b[i]) == 1) ? 32'd0 : 32'd1);
      wait_valid();
      @(negedge clk);
      check("hold_valid", 32'(bus.o_div_valid), 32'd0);
      check("hold_result", bus.o_div_result, last_exp);
    end

    // A start arriving mid-calculation must not disturb the running operation.
    issue(2'b01, 32'd1000, 32'd9, 1'b1);
    repeat (4) @(negedge clk);
    check("busy_mid_calc", 32'(bus.o_div_busy), 32'd1);
    bus.i_div_start = 1'b1;
    bus.i_div_op    = 2'b11;
    bus.i_div_a     = 32'd77;
    bus.i_div_b     = 32'd5;
    @(negedge clk);
    bus.i_div_start = 1'b0;
    wait_valid();
    @(negedge clk);
    check("ignored_start_idle", 32'(bus.o_div_busy), 32'd0);

    // Back-to-back: new start presented in the DONE cycle.
    issue(2'b00, 32'hFFFF_FC18, 32'd33, 1'b1);
    wait_valid();
    issue(2'b10, 32'hFFFF_FC18, 32'd33, 1'b1);
    wait_valid();
    @(negedge clk);

    // Reset mid-CALC, with a start held alongside it, aborts silently.
    issue(2'b01, 32'hDEAD_BEEF, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    bus.i_div_start = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus.o_div_busy), 32'd0);
    check("abort_valid", 32'(bus.o_div_valid), 32'd0);
    check("abort_result", bus.o_div_result, 32'd0);
    rst = 1'b0;
    bus.i_div_start = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_still_idle", 32'(bus.o_div_busy), 32'd0);

    for (int n = 0; n < 150; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      issue(op, a, b, 1'b1);
      wait_valid();
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div_32.md
DIV_32 -- requirements
Module: div_32

Interface
REQ-001 The block SHALL have a single clock and a reset that is synchronous and active-high, with ports named i_clk and i_reset.
REQ-002 Parameter WIDTH, default 32, SHALL set the operand and result width; only 32 is required to be supported.
REQ-003 i_clk  input  1  rising-edge clock.
REQ-004 i_reset  input  1  synchronous active-high reset.
REQ-005 i_div_start  input  1  request; sampled only when the block is accepting.
REQ-006 i_div_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 i_div_a  input  WIDTH  dividend.
REQ-008 i_div_b  input  WIDTH  divisor.
REQ-009 o_div_busy  output  1  high while iterating; the block is not accepting.
REQ-010 o_div_valid  output  1  single-cycle pulse marking o_div_result valid.
REQ-011 o_div_result  output  WIDTH  quotient or remainder, per the latched op.

Function
REQ-012 The FSM SHALL have three states:
- IDLE: waits for a start request.
- CALC: performs WIDTH restoring-subtraction iterations, one per clock.
- DONE: lasts exactly one cycle.
REQ-013 The block SHALL accept a start request only in IDLE or DONE, i.e. when o_div_busy=0; i_div_start while in CALC SHALL be ignored with no effect.
REQ-014 On an accepted start edge, the block SHALL:
- latch i_div_op;
- latch |a| and |b| for signed ops, or raw a and b for unsigned ops;
- clear the iteration counter to 0;
- enter CALC.
REQ-015 Each CALC edge SHALL perform one step:
- shift the {remainder, quotient} pair left by one bit;
- subtract the divisor from the remainder;
- if the difference is non-negative, keep it and set the quotient LSB to 1; otherwise restore the remainder and set the LSB to 0.
REQ-016 After the WIDTH-th CALC edge, the block SHALL enter DONE; o_div_valid SHALL be 1 in exactly that cycle, which is WIDTH+1 cycles after the start edge.
REQ-017 In DONE with no start request, the next edge SHALL return the FSM to IDLE; with a start request, the next edge SHALL start a new operation (back-to-back).
REQ-018 Sign fix-up for signed ops SHALL be applied when the result register is loaded:
- quotient is negated when the operand signs differ;
- remainder takes the sign of the dividend.
REQ-019 Divide by zero SHALL return:
- DIV/DIVU: 0xFFFFFFFF;
- REM/REMU: the original i_div_a.
REQ-020 Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF) SHALL return:
- DIV: 0x80000000;
- REM: 0x00000000.
REQ-021 o_div_result SHALL be 0 until the first completion, then SHALL hold its last completed value until the next completion updates it.
REQ-022 o_div_busy SHALL be 1 exactly in CALC; o_div_valid SHALL be 1 exactly in DONE.

Reset
REQ-023 i_reset=1 at any edge, including mid-CALC, SHALL abort the operation and force:
- FSM to IDLE and counter to 0;
- o_div_busy=0, o_div_valid=0, o_div_result=0.
REQ-024 A start request coincident with i_reset SHALL be ignored; reset has priority.

Configuration
REQ-025 When macro DIV_EARLY_OUT_EN is defined, divide-by-zero and signed-overflow requests SHALL bypass CALC:
- the block SHALL go directly to DONE on the edge after the start edge;
- results SHALL follow REQ-019/020;
- o_div_busy SHALL stay 0.
REQ-026 When DIV_EARLY_OUT_EN is undefined, every operation SHALL take the full WIDTH+1-cycle latency, with special-case results still per REQ-019/020.

Verification
REQ-027 DIVU a=100, b=7 -> o_div_valid pulses 33 cycles after start with result 14; REMU on the same operands -> 2.
REQ-028 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD (-3); REM on the same operands -> 0xFFFFFFFF (-1).
REQ-029 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0x00000000.
REQ-030 DIVU a=5, b=0 -> 0xFFFFFFFF; REMU a=5, b=0 -> 5; valid at 33 cycles with the macro undefined, at 1 cycle with DIV_EARLY_OUT_EN defined.
REQ-031 Start accepted, then i_reset=1 at CALC cycle 10 -> next cycle busy=0, valid=0, result=0, and no valid pulse follows.
REQ-032 Start at CALC cycle 5 is ignored (original result delivered); start during DONE -> second result valid exactly 33 cycles later.
